// File: rtl/subtract_frame_seq.sv
// rtl/subtract_frame_seq.sv - frame-level sequencer around the background-subtract stage
//
// Admits exactly one frame (WIDTH*HEIGHT pixel pairs) from the base/image
// FIFOs into the subtract stage on start, then blocks further reads. It waits
// until every result byte has been written to the output FIFO, then pulses
// frame_done. It also flags base/image read skew and output overrun in a
// sticky err bit.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   start, continuous   frame start request / auto-restart after each frame
//   busy, frame_done    RUN|DRAIN indicator, one-cycle end-of-frame pulse
//   frame_count, err    completed frames (wrapping), sticky error flag
//   fifo_empty_*        empty flags from base/image input FIFOs
//   fifo_rd_en_*        gated read enables to base/image input FIFOs
//   sub_empty_*         gated empty flags presented to the subtract stage
//   sub_rd_en_*         read requests from the subtract stage
//   sub_wr_en           result write strobe from the subtract stage
//   fifo_wr_en          write enable to the output FIFO
//   fifo_full_out       full flag of the output FIFO

module subtract_frame_seq #(
   parameter int WIDTH  = 720,
   parameter int HEIGHT = 540,
   parameter int FCNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              continuous,
   output logic              busy,
   output logic              frame_done,
   output logic [FCNT_W-1:0] frame_count,
   output logic              err,
   input  logic              fifo_empty_base,
   input  logic              fifo_empty_img,
   output logic              fifo_rd_en_base,
   output logic              fifo_rd_en_img,
   output logic              sub_empty_base,
   output logic              sub_empty_img,
   input  logic              sub_rd_en_base,
   input  logic              sub_rd_en_img,
   input  logic              sub_wr_en,
   output logic              fifo_wr_en,
   input  logic              fifo_full_out
);

   localparam int NPIX = WIDTH * HEIGHT;
   localparam int CW   = $clog2(NPIX + 1);
   localparam logic [CW-1:0] NPIX_C = CW'(NPIX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] in_cnt;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] in_nx;
   logic [CW-1:0] out_nx;
   logic          allow;
   logic          pix_rd;
   logic          skew;
   logic          out_inc;
   logic          clr_cnt;
   logic          err_set;

   // Reads are only let through while a frame is running and not yet fully
   // admitted; this also masks a read enable the subtract stage keeps high.
   assign allow           = (state == S_RUN) && (in_cnt < NPIX_C);
   assign sub_empty_base  = ~allow | fifo_empty_base;
   assign sub_empty_img   = ~allow | fifo_empty_img;
   assign fifo_rd_en_base = sub_rd_en_base & allow & ~fifo_empty_base;
   assign fifo_rd_en_img  = sub_rd_en_img & allow & ~fifo_empty_img;
   assign fifo_wr_en      = sub_wr_en & ~fifo_full_out;

   // A pixel is only consumed when both streams advance together.
   assign pix_rd  = fifo_rd_en_base & fifo_rd_en_img;
   assign skew    = fifo_rd_en_base ^ fifo_rd_en_img;
   assign out_inc = fifo_wr_en && ((state == S_RUN) || (state == S_DRAIN));
   assign in_nx   = in_cnt + CW'(pix_rd);
   assign out_nx  = out_cnt + CW'(out_inc);

   // Writes outside a frame are passed through but still flagged.
   assign err_set = skew
                  | (sub_wr_en & fifo_full_out)
                  | (fifo_wr_en & ((state == S_IDLE) || (state == S_DONE)));

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      clr_cnt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_RUN;
               clr_cnt  = 1'b1;
            end
         end
         S_RUN: begin
            // The last write may land in the same cycle as the last read.
            if (pix_rd && (in_nx == NPIX_C)) begin
               state_nx = (out_nx == NPIX_C) ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_nx == NPIX_C) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            if (continuous | start) begin
               state_nx = S_RUN;
               clr_cnt  = 1'b1;
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Moore outputs
   always_comb begin
      frame_done = (state == S_DONE);
      busy       = (state == S_RUN) || (state == S_DRAIN);
   end

   // Counters and sticky error
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         in_cnt      <= '0;
         out_cnt     <= '0;
         frame_count <= '0;
         err         <= 1'b0;
      end else begin
         if (clr_cnt) begin
            in_cnt  <= '0;
            out_cnt <= '0;
         end else begin
            in_cnt  <= in_nx;
            out_cnt <= out_nx;
         end
         if (state == S_DONE) begin
            frame_count <= frame_count + FCNT_W'(1);
         end
         if (err_set) begin
            err <= 1'b1;
         end
      end
   end

endmodule
